// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns instruction words into the ALU control bundle and
// buffers them behind a two-entry skid buffer so in_ready is always a flop.
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [1:0]      out_a_sel,
    output logic            out_b_sel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_pc,
    output logic            out_reg_we,
    output logic            out_illegal
);

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [1:0]      a_sel;
        logic            b_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic            reg_we;
        logic            illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    // Base register/immediate ALU mapping shared by OP and OP-IMM.
    function automatic logic [3:0] funct3_to_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

    assign opcode    = in_inst[6:0];
    assign funct3    = in_inst[14:12];
    assign funct7    = in_inst[31:25];
    assign imm_i     = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
    assign imm_u     = {in_inst[31:12], 12'd0};
    assign imm_j     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
    assign imm_shamt = {27'd0, in_inst[24:20]};

    ctrl_t dec;
    logic  dec_legal;
    logic  dec_writes;

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_XXX;
        dec.rd     = in_inst[11:7];
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec.pc     = in_pc;
        dec_legal  = 1'b0;
        dec_writes = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_writes = 1'b1;
                if (funct7 == 7'h00) begin
                    dec.alu_op = funct3_to_op(funct3);
                    dec_legal  = 1'b1;
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    dec.alu_op = ALU_SUB;
                    dec_legal  = 1'b1;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    dec.alu_op = ALU_SRA;
                    dec_legal  = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.b_sel  = 1'b1;
                dec_writes = 1'b1;
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    // Shifts: upper immediate bits act as funct7, shamt is unsigned.
                    dec.imm = imm_shamt;
                    if (funct7 == 7'h00) begin
                        dec.alu_op = funct3_to_op(funct3);
                        dec_legal  = 1'b1;
                    end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                        dec.alu_op = ALU_SRA;
                        dec_legal  = 1'b1;
                    end
                end else begin
                    dec.alu_op = funct3_to_op(funct3);
                    dec.imm    = imm_i;
                    dec_legal  = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.alu_op = ALU_COPY_B;
                dec.a_sel  = A_ZERO;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec_writes = 1'b1;
                dec_legal  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = A_PC;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec_writes = 1'b1;
                dec_legal  = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = A_RS1;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                dec_writes = 1'b1;
                dec_legal  = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = A_RS1;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_s;
                dec_legal  = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op = ALU_ADD;
                dec.a_sel  = A_PC;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_j;
                dec_writes = 1'b1;
                dec_legal  = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'd0) begin
                    dec.alu_op = ALU_ADD;
                    dec.a_sel  = A_RS1;
                    dec.b_sel  = 1'b1;
                    dec.imm    = imm_i;
                    dec_writes = 1'b1;
                    dec_legal  = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // The ALU is idle for branches; the comparator reads rs1/rs2 directly.
                dec.alu_op = ALU_XXX;
                dec.a_sel  = A_RS1;
                dec.imm    = imm_b;
                dec_legal  = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec.alu_op = ALU_XXX;
            dec.a_sel  = A_RS1;
            dec.b_sel  = 1'b0;
            dec.imm    = '0;
        end
        dec.illegal = !dec_legal;
        dec.reg_we  = dec_writes && dec_legal && (in_inst[11:7] != 5'd0);
    end

    state_t state_q, state_d;
    ctrl_t  main_q, main_d;
    ctrl_t  skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   in_hs, out_hs;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_hs) begin
                        main_d  = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_hs && out_hs) begin
                        main_d = dec;
                    end else if (in_hs) begin
                        skid_d  = dec;
                        state_d = S_FULL;
                    end else if (out_hs) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_alu_op  = main_q.alu_op;
    assign out_a_sel   = main_q.a_sel;
    assign out_b_sel   = main_q.b_sel;
    assign out_imm     = main_q.imm;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_pc      = main_q.pc;
    assign out_reg_we  = main_q.reg_we;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed decode checks, backpressure, flush,
// async reset and a long random stream checked through a scoreboard queue.
module tb_alu_decode_stage;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    typedef logic [87:0] bundle_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_imm, out_pc;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_a_sel;
    logic        out_b_sel, out_reg_we, out_illegal;
    logic [4:0]  out_rd, out_rs1, out_rs2;

    bundle_t sb_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      out_hs   = 0;

    alu_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
        .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_pc(out_pc), .out_reg_we(out_reg_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input bundle_t got, input bundle_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        return tbl[f3];
    endfunction

    function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
        logic [3:0]  op;
        logic [1:0]  a;
        logic        b, we, ill;
        logic [31:0] imm, imm_i;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3 = i[14:12];
        f7 = i[31:25];
        imm_i = {{20{i[31]}}, i[31:20]};
        op = ALU_XXX; a = 2'd0; b = 1'b0; imm = 32'd0; we = 1'b0; ill = 1'b1;
        case (i[6:0])
            7'h33: begin
                we = 1'b1;
                if (f7 == 7'h00) begin op = base_op(f3); ill = 1'b0; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin op = ALU_SUB; ill = 1'b0; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin op = ALU_SRA; ill = 1'b0; end
            end
            7'h13: begin
                b = 1'b1; we = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    imm = {27'd0, i[24:20]};
                    if (f7 == 7'h00) begin op = base_op(f3); ill = 1'b0; end
                    else if (f7 == 7'h20 && f3 == 3'd5) begin op = ALU_SRA; ill = 1'b0; end
                end else begin
                    op = base_op(f3); imm = imm_i; ill = 1'b0;
                end
            end
            7'h37: begin op = ALU_COPY_B; a = 2'd2; b = 1'b1; imm = {i[31:12], 12'd0}; we = 1'b1; ill = 1'b0; end
            7'h17: begin op = ALU_ADD; a = 2'd1; b = 1'b1; imm = {i[31:12], 12'd0}; we = 1'b1; ill = 1'b0; end
            7'h03: begin op = ALU_ADD; b = 1'b1; imm = imm_i; we = 1'b1; ill = 1'b0; end
            7'h23: begin op = ALU_ADD; b = 1'b1; imm = {{20{i[31]}}, i[31:25], i[11:7]}; ill = 1'b0; end
            7'h6F: begin
                op = ALU_ADD; a = 2'd1; b = 1'b1; we = 1'b1; ill = 1'b0;
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: if (f3 == 3'd0) begin op = ALU_ADD; b = 1'b1; imm = imm_i; we = 1'b1; ill = 1'b0; end
            7'h63: begin
                op = ALU_XXX; ill = 1'b0;
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin op = ALU_XXX; a = 2'd0; b = 1'b0; imm = 32'd0; we = 1'b0; end
        if (i[11:7] == 5'd0) we = 1'b0;
        return {op, a, b, imm, i[11:7], i[19:15], i[24:20], pc, we, ill};
    endfunction

    function automatic bundle_t got_bundle();
        return {out_alu_op, out_a_sel, out_b_sel, out_imm, out_rd, out_rs1, out_rs2,
                out_pc, out_reg_we, out_illegal};
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int          k, m;
        w = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h03;
            5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h6F;
            7: w[6:0] = 7'h67;
            8: w[6:0] = 7'h63;
            default: ;
        endcase
        m = $urandom_range(0, 3);
        if (m == 0) w[31:25] = 7'h00;
        else if (m == 1) w[31:25] = 7'h20;
        if ($urandom_range(0, 3) == 0) w[14:12] = 3'd0;
        return w;
    endfunction

    // Scoreboard: outputs are popped before this cycle's input is pushed.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_hs++;
                if (sb_q.size() == 0) check_eq("sb_unexpected", 88'(out_valid), 88'(0));
                else check_eq("sb_order", got_bundle(), sb_q.pop_front());
            end
            if (in_valid && in_ready) sb_q.push_back(model(in_inst, in_pc));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic send1(input logic [31:0] inst, input logic [31:0] pc);
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int          n, cyc, hs0;
        logic        acc;
        logic [31:0] ins [4];
        ins = '{32'h003100B3, 32'h407302B3, 32'h123450B7, 32'h40315093};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 88'(out_valid), 88'(0));
        check_eq("rst_ready", 88'(in_ready), 88'(1));
        check_eq("rst_data", got_bundle(), 88'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        send1(32'h003100B3, 32'h1000);
        check_eq("add_valid", 88'(out_valid), 88'(1));
        check_eq("add_op", 88'(out_alu_op), 88'(ALU_ADD));
        check_eq("add_sel", 88'({out_a_sel, out_b_sel}), 88'(0));
        check_eq("add_regs", 88'({out_rd, out_rs1, out_rs2}), 88'({5'd1, 5'd2, 5'd3}));
        check_eq("add_we_ill", 88'({out_reg_we, out_illegal}), 88'(2'b10));
        send1(32'h407302B3, 32'h1004);
        check_eq("sub_op", 88'(out_alu_op), 88'(ALU_SUB));
        send1(32'h40315093, 32'h1008);
        check_eq("srai_op", 88'(out_alu_op), 88'(ALU_SRA));
        check_eq("srai_b_imm", 88'({out_b_sel, out_imm}), 88'({1'b1, 32'd3}));
        send1(32'h123450B7, 32'h100C);
        check_eq("lui_op", 88'(out_alu_op), 88'(ALU_COPY_B));
        check_eq("lui_imm", 88'(out_imm), 88'(32'h12345000));
        send1(32'h00001017, 32'h1010);
        check_eq("auipc_op_a", 88'({out_alu_op, out_a_sel}), 88'({ALU_ADD, 2'd1}));
        check_eq("auipc_we", 88'(out_reg_we), 88'(0));
        send1(32'hFFFFFFFF, 32'h1014);
        check_eq("ill_flags", 88'({out_illegal, out_reg_we}), 88'(2'b10));
        check_eq("ill_op", 88'(out_alu_op), 88'(ALU_XXX));
        @(posedge clk); #1;
        check_eq("dir_empty", 88'(out_valid), 88'(0));

        // Backpressure: two entries accepted, then in_ready drops.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = ins[0]; in_pc = 32'h2000;
        @(posedge clk); #1;
        check_eq("bp_ready1", 88'(in_ready), 88'(1));
        in_inst = ins[1]; in_pc = 32'h2004;
        @(posedge clk); #1;
        check_eq("bp_ready2", 88'(in_ready), 88'(0));
        in_inst = ins[2]; in_pc = 32'h2008;
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_hold", got_bundle(), model(ins[0], 32'h2000));
        check_eq("bp_stall", 88'({out_valid, in_ready}), 88'(2'b10));
        hs0 = out_hs;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_inst = ins[3]; in_pc = 32'h200C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("bp_nogap", 88'(out_hs - hs0), 88'(4));
        check_eq("bp_drain", 88'(out_valid), 88'(0));

        // Flush while full, with a new instruction presented in the same cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = ins[0]; in_pc = 32'h3000;
        @(posedge clk); #1;
        in_inst = ins[1]; in_pc = 32'h3004;
        @(posedge clk); #1;
        check_eq("fl_full", 88'(in_ready), 88'(0));
        in_inst = 32'h00500113; in_pc = 32'h3008; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check_eq("fl_state", 88'({out_valid, in_ready}), 88'(2'b01));
        out_ready = 1'b1;
        hs0 = out_hs;
        repeat (3) @(posedge clk);
        #1;
        check_eq("fl_none", 88'(out_hs - hs0), 88'(0));
        send1(ins[2], 32'h300C);
        check_eq("fl_next", got_bundle(), model(ins[2], 32'h300C));
        @(posedge clk); #1;

        // Asynchronous reset mid-stream, away from any clock edge.
        out_ready = 1'b0;
        send1(ins[1], 32'h4000);
        check_eq("arst_pre", 88'(out_valid), 88'(1));
        #1 rst = 1'b1;
        #1;
        check_eq("arst_state", 88'({out_valid, in_ready}), 88'(2'b01));
        check_eq("arst_data", got_bundle(), 88'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Random stream against the model.
        n = 0; cyc = 0;
        while (n < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                in_inst  = gen_inst();
                in_pc    = $urandom();
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rand_count", 88'(n), 88'(10000));
        check_eq("rand_drain", 88'(sb_q.size()), 88'(0));
        check_eq("rand_idle", 88'({out_valid, in_ready}), 88'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
